// File: rtl/mau_store_buffer.sv
// rtl/mau_store_buffer.sv - in-order store buffer between MAU and the data memory port
// Stalls the pipe when full or when a load touches a word still waiting to drain.
module mau_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          StepMAU,
  input  logic          WorkMAU,
  input  logic          MAUStore,
  input  logic          MAULoad,
  input  logic [AW-1:0] MAUAddr,
  input  logic [DW-1:0] MAUData,
  output logic          nMAUNotReady,
  output logic          MemReq,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemData,
  input  logic          MemAck,
  output logic          SBEmpty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic [AW-1:0] addrMem [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic fullStall;
  logic loadHit;

  assign full      = (count == (PW+1)'(DEPTH));
  assign push      = StepMAU & WorkMAU & MAUStore & ~full;
  assign MemReq    = (count != '0);
  assign pop       = MemReq & MemAck;
  assign SBEmpty   = (count == '0);
  assign MemAddr   = addrMem[rdPtr];
  assign MemData   = dataMem[rdPtr];
  assign fullStall = WorkMAU & MAUStore & full;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= MAUAddr;
      dataMem[wrPtr] <= MAUData;
    end
  end

  // A slot is live when its distance from the head is below count.
  always_comb begin
    loadHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - rdPtr} < count) &&
          (addrMem[i][AW-1:2] == MAUAddr[AW-1:2]))
        loadHit = 1'b1;
    end
    loadHit = loadHit & WorkMAU & MAULoad;
  end

  assign nMAUNotReady = ~(fullStall | loadHit);

endmodule

// File: tb/tb_mau_store_buffer.sv
// tb/tb_mau_store_buffer.sv - self-checking bench for mau_store_buffer
// Hand-derived vector table, a mid-drain reset sequence, then random traffic against a queue model.
module tb_mau_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        nReset;
  logic        StepMAU;
  logic        WorkMAU;
  logic        MAUStore;
  logic        MAULoad;
  logic [31:0] MAUAddr;
  logic [31:0] MAUData;
  logic        nMAUNotReady;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemAck;
  logic        SBEmpty;

  int checks   = 0;
  int failures = 0;

  mau_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .StepMAU      (StepMAU),
    .WorkMAU      (WorkMAU),
    .MAUStore     (MAUStore),
    .MAULoad      (MAULoad),
    .MAUAddr      (MAUAddr),
    .MAUData      (MAUData),
    .nMAUNotReady (nMAUNotReady),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemData      (MemData),
    .MemAck       (MemAck),
    .SBEmpty      (SBEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step, work, store, load, ack;
    logic [31:0] addr, data;
    logic        eReq;
    logic [31:0] eAddr, eData;
    logic        eEmpty, eNr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic w, input logic st, input logic ld,
                              input logic ak, input logic [31:0] a, input logic [31:0] d,
                              input logic er, input logic [31:0] ea, input logic [31:0] ed,
                              input logic ee, input logic en);
    vec_t v;
    v.step = s; v.work = w; v.store = st; v.load = ld; v.ack = ak;
    v.addr = a; v.data = d; v.eReq = er; v.eAddr = ea; v.eData = ed;
    v.eEmpty = ee; v.eNr = en;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    StepMAU = 0; WorkMAU = 0; MAUStore = 0; MAULoad = 0;
    MAUAddr = '0; MAUData = '0; MemAck = 0;
  endtask

  logic [31:0] qa[$];
  logic [31:0] qd[$];

  initial begin
    logic hit, eReq, eNr, doPop, doPush;
    int r;

    // Row format: step work store load ack addr data | req addr data empty nNotReady
    // basic drain with MemAck held high, then bubble store and ack while empty
    add(1,1,1,0,1, 32'h100, 32'hD0000100, 0, 0, 0, 1, 1);
    add(1,1,1,0,1, 32'h104, 32'hD0000104, 1, 32'h100, 32'hD0000100, 0, 1);
    add(0,0,0,0,1, 0, 0,                  1, 32'h104, 32'hD0000104, 0, 1);
    add(0,0,0,0,1, 0, 0,                  0, 0, 0, 1, 1);
    add(1,0,1,0,1, 32'h300, 32'hD0000300, 0, 0, 0, 1, 1);
    add(0,0,0,0,0, 0, 0,                  0, 0, 0, 1, 1);
    // load hazard on word 0x200
    add(1,1,1,0,0, 32'h200, 32'hD0000200, 0, 0, 0, 1, 1);
    add(0,1,0,1,0, 32'h202, 0,            1, 32'h200, 32'hD0000200, 0, 0);
    add(1,1,0,1,0, 32'h204, 0,            1, 32'h200, 32'hD0000200, 0, 1);
    add(0,1,0,1,1, 32'h202, 0,            1, 32'h200, 32'hD0000200, 0, 0);
    add(1,1,0,1,0, 32'h202, 0,            0, 0, 0, 1, 1);
    // fill to DEPTH, stall the fifth store, single ack
    add(1,1,1,0,0, 32'h100, 32'hD0000100, 0, 0, 0, 1, 1);
    add(1,1,1,0,0, 32'h104, 32'hD0000104, 1, 32'h100, 32'hD0000100, 0, 1);
    add(1,1,1,0,0, 32'h108, 32'hD0000108, 1, 32'h100, 32'hD0000100, 0, 1);
    add(1,1,1,0,0, 32'h10C, 32'hD000010C, 1, 32'h100, 32'hD0000100, 0, 1);
    add(1,1,1,0,0, 32'h110, 32'hD0000110, 1, 32'h100, 32'hD0000100, 0, 0);
    add(1,1,1,0,1, 32'h110, 32'hD0000110, 1, 32'h100, 32'hD0000100, 0, 0);
    add(1,1,1,0,0, 32'h110, 32'hD0000110, 1, 32'h104, 32'hD0000104, 0, 1);
    add(0,0,0,0,0, 0, 0,                  1, 32'h104, 32'hD0000104, 0, 1);
    add(1,1,1,0,0, 32'h114, 32'hD0000114, 1, 32'h104, 32'hD0000104, 0, 0);
    add(0,0,0,0,1, 0, 0,                  1, 32'h104, 32'hD0000104, 0, 1);
    add(0,0,0,0,1, 0, 0,                  1, 32'h108, 32'hD0000108, 0, 1);
    add(0,0,0,0,1, 0, 0,                  1, 32'h10C, 32'hD000010C, 0, 1);
    add(0,0,0,0,1, 0, 0,                  1, 32'h110, 32'hD0000110, 0, 1);
    add(0,0,0,0,0, 0, 0,                  0, 0, 0, 1, 1);

    idle_inputs();
    nReset = 0;
    #2;
    chk("reset_memreq", MemReq, 0);
    chk("reset_sbempty", SBEmpty, 1);
    chk("reset_nnotready", nMAUNotReady, 1);
    @(posedge clk);
    @(negedge clk);
    nReset = 1;

    foreach (vecs[k]) begin
      @(negedge clk);
      StepMAU = vecs[k].step; WorkMAU = vecs[k].work; MAUStore = vecs[k].store;
      MAULoad = vecs[k].load; MemAck = vecs[k].ack;
      MAUAddr = vecs[k].addr; MAUData = vecs[k].data;
      #1;
      chk($sformatf("vec%0d_memreq", k), MemReq, vecs[k].eReq);
      chk($sformatf("vec%0d_sbempty", k), SBEmpty, vecs[k].eEmpty);
      chk($sformatf("vec%0d_nnotready", k), nMAUNotReady, vecs[k].eNr);
      if (vecs[k].eReq) begin
        chk($sformatf("vec%0d_memaddr", k), MemAddr, vecs[k].eAddr);
        chk($sformatf("vec%0d_memdata", k), MemData, vecs[k].eData);
      end
    end

    // reset while three entries wait and a load hits one of them
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      StepMAU = 1; WorkMAU = 1; MAUStore = 1; MAULoad = 0; MemAck = 0;
      MAUAddr = 32'h500 + 32'(i) * 4; MAUData = 32'hBEEF0000 + 32'(i);
    end
    @(negedge clk);
    StepMAU = 0; WorkMAU = 1; MAUStore = 0; MAULoad = 1; MemAck = 0;
    MAUAddr = 32'h504;
    #1;
    chk("premid_memreq", MemReq, 1);
    chk("premid_nnotready", nMAUNotReady, 0);
    #1;
    nReset = 0;
    #1;
    chk("midreset_memreq", MemReq, 0);
    chk("midreset_sbempty", SBEmpty, 1);
    chk("midreset_nnotready", nMAUNotReady, 1);
    @(negedge clk);
    idle_inputs();
    nReset = 1;

    // random traffic against an in-order queue model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 3);
      WorkMAU  = ($urandom_range(0, 3) != 0);
      MAUStore = (r < 2);
      MAULoad  = (r == 2);
      StepMAU  = $urandom_range(0, 1);
      MemAck   = $urandom_range(0, 1);
      MAUAddr  = 32'h400 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
      MAUData  = $urandom;
      #1;
      hit = 0;
      foreach (qa[i]) if (qa[i][31:2] == MAUAddr[31:2]) hit = 1;
      eReq = (qa.size() != 0);
      eNr  = !((WorkMAU && MAUStore && qa.size() == DEPTH) || (WorkMAU && MAULoad && hit));
      chk("rnd_memreq", MemReq, eReq);
      chk("rnd_sbempty", SBEmpty, !eReq);
      chk("rnd_nnotready", nMAUNotReady, eNr);
      if (eReq) begin
        chk("rnd_memaddr", MemAddr, qa[0]);
        chk("rnd_memdata", MemData, qd[0]);
      end
      doPop  = eReq && MemAck;
      doPush = StepMAU && WorkMAU && MAUStore && (qa.size() < DEPTH);
      @(posedge clk);
      if (doPop) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (doPush) begin
        qa.push_back(MAUAddr);
        qd.push_back(MAUData);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
